mfcc_frame_packer: RTL
======================

// Module: mfcc_frame_packer
// PURPOSE
//  Downstream stage of MFCC_Core. Captures one full MFCC coefficient vector on frame_valid_i.
//  Serializes it into a framed byte packet for the byte-wide TX FIFO that feeds the SPI slave.
//  Replaces the single-coefficient, 2-byte writer. Adds sync byte, sequence number and XOR checksum.
//  Host can detect lost or corrupted frames.
// PARAMETERS
//  NUM_COEFFS  12    coefficients per frame
//  COEF_WIDTH  16    bits per coefficient (multiple of 8)
//  SYNC_BYTE   8'hA5 first byte of every packet
//  CNT_WIDTH   16    width of the frames_sent/frames_dropped counters
// PORTS
//  clk             in   1                      system clock
//  rst_n           in   1                      async active-low reset
//  frame_valid_i   in   1                      1-cycle pulse: coeffs_i valid (MFCC_Core mfcc_done)
//  coeffs_i        in   NUM_COEFFS*COEF_WIDTH  coeff k at [k*COEF_WIDTH +: COEF_WIDTH]
//  fifo_full_i     in   1                      TX FIFO full
//  fifo_wr_en_o    out  1                      FIFO write strobe
//  fifo_data_o     out  8                      FIFO write byte
//  busy_o          out  1                      packet in progress
//  pkt_done_o      out  1                      1-cycle pulse after last byte written
//  seq_o           out  8                      sequence number of next packet
//  frames_sent_o   out  CNT_WIDTH              packets completed, saturating
//  frames_dropped_o out CNT_WIDTH              frames rejected while busy, saturating
// BEHAVIOUR
//  Clock and reset: clk; rst_n asynchronous, active-low.
//  Reset values:
//   - All outputs and counters 0; state IDLE; seq 0.
//   - Reset mid-packet aborts the packet. Partial bytes already in the FIFO are not retracted.
//  Packet format: PKT_LEN = 3 + NUM_COEFFS*COEF_WIDTH/8 bytes (27 with defaults).
//   - Byte 0: SYNC_BYTE.
//   - Byte 1: seq.
//   - Data bytes: coeff 0..NUM_COEFFS-1, each little-endian (LSB first).
//   - Last byte: XOR of bytes 1..PKT_LEN-2 (seq and data; sync excluded).
//  FSM states:
//   - IDLE: frame_valid_i=1 -> latch coeffs_i and seq into shadow regs; idx=0; chk=0 -> SEND.
//   - SEND: byte[idx] is driven on fifo_data_o combinationally from the shadow regs.
//     - fifo_wr_en_o = !fifo_full_i (combinational). Never write while full.
//     - On a write: chk ^= byte (idx 1..PKT_LEN-2), then idx++.
//     - On the write at idx = PKT_LEN-1: go to DONE.
//     - While fifo_full_i=1: hold idx, chk and data; no write.
//   - DONE (1 cycle):
//     - pkt_done_o=1; seq++ (wraps 255 -> 0); frames_sent++ (saturates at all-ones) -> IDLE.
//  Signal rules:
//   - busy_o = (state != IDLE).
//   - A frame_valid_i in SEND or DONE is dropped: frames_dropped++ (saturating). Shadow regs unchanged.
//   - Throughput: with FIFO never full, one byte per cycle.
//     Packet takes PKT_LEN+1 cycles from frame_valid_i to pkt_done_o.
//   - Latency: first write occurs the cycle after frame_valid_i (SEND entry), if not full.
//   - coeffs_i is sampled only on the accepting edge. It may change afterwards.
//   - Shadow registers are not reset-critical. Counters and FSM are reset.
// TESTING
//  1. Basic: seq=0, coeff0=0x1234, all other coeffs 0, FIFO never full.
//     -> 27 consecutive writes: A5,00,34,12, then 22x 00, then 26.
//     -> pkt_done_o at cycle 28; seq_o=1; frames_sent_o=1.
//  2. Backpressure: hold fifo_full_i=1 for 5 cycles at idx 10.
//     -> no fifo_wr_en_o while full; byte 10 held; stream resumes unchanged.
//     -> identical byte sequence and checksum to the same frame sent without stalls.
//  3. Overrun: second frame_valid_i at idx 5 of packet 0.
//     -> frames_dropped_o=1; packet 0 bytes uncorrupted.
//     -> next frame_valid_i after pkt_done_o is accepted with seq=1.
//  4. Seq wrap: send 257 frames.
//     -> packet 255 carries seq FF; packet 256 carries seq 00; frames_sent_o=257.
//  5. Reset mid-packet: assert rst_n=0 at idx 13 asynchronously.
//     -> outputs 0 immediately; after release, next frame starts with A5,00 and seq restarts at 0.
//  6. Saturation: CNT_WIDTH=2; 5 dropped frames -> frames_dropped_o holds 3.

Source files
------------

// File: rtl/mfcc_frame_packer.sv
// Packs one MFCC coefficient vector into a framed byte packet:
// sync, sequence number, little-endian coefficients, XOR checksum.
module mfcc_frame_packer #(
   parameter int NUM_COEFFS = 12,
   parameter int COEF_WIDTH = 16,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int CNT_WIDTH = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             frame_valid_i,
   input  logic [NUM_COEFFS*COEF_WIDTH-1:0] coeffs_i,
   input  logic                             fifo_full_i,
   output logic                             fifo_wr_en_o,
   output logic [7:0]                       fifo_data_o,
   output logic                             busy_o,
   output logic                             pkt_done_o,
   output logic [7:0]                       seq_o,
   output logic [CNT_WIDTH-1:0]             frames_sent_o,
   output logic [CNT_WIDTH-1:0]             frames_dropped_o
);

   localparam int DW = NUM_COEFFS * COEF_WIDTH;
   localparam int PKT_LEN = 3 + DW / 8;
   localparam int IW = $clog2(PKT_LEN + 1);
   localparam int SW = IW + 3;
   localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [7:0]      chk;
   logic [7:0]      seq;
   logic [7:0]      seq_sh;
   logic [DW-1:0]   data_sh;
   logic [7:0]      cur_byte;
   logic [IW-1:0]   di;
   logic [SW-1:0]   bit_base;
   logic            accept;
   logic            wr;

   assign accept = (state == IDLE) && frame_valid_i;
   assign wr = (state == SEND) && !fifo_full_i;
   assign di = idx - IW'(2);
   assign bit_base = {di, 3'b000};

   always_comb begin
      cur_byte = '0;
      unique case (1'b1)
         idx == '0:   cur_byte = SYNC_BYTE;
         idx == IW'(1): cur_byte = seq_sh;
         idx == LAST: cur_byte = chk;
         default:     cur_byte = data_sh[bit_base +: 8];
      endcase
   end

   assign fifo_wr_en_o = wr;
   assign fifo_data_o = (state == SEND) ? cur_byte : 8'h00;
   assign busy_o = (state != IDLE);
   assign pkt_done_o = (state == DONE);
   assign seq_o = seq;

   // Shadow copy only matters once a frame is accepted, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         data_sh <= coeffs_i;
         seq_sh <= seq;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx <= '0;
         chk <= '0;
         seq <= '0;
         frames_sent_o <= '0;
         frames_dropped_o <= '0;
      end else begin
         if (frame_valid_i && state != IDLE &&
             frames_dropped_o != '1)
            frames_dropped_o <= frames_dropped_o + 1'b1;
         unique case (state)
            IDLE: begin
               if (frame_valid_i) begin
                  idx <= '0;
                  chk <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (wr) begin
                  if (idx != '0 && idx != LAST)
                     chk <= chk ^ cur_byte;
                  idx <= idx + 1'b1;
                  if (idx == LAST)
                     state <= DONE;
               end
            end
            DONE: begin
               seq <= seq + 8'd1;
               if (frames_sent_o != '1)
                  frames_sent_o <= frames_sent_o + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
